// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM states and mode encodings.
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/serial_addsub_slice.sv
// Combinational BITS_PER_CYCLE-wide ripple slice of 1-bit add/subtract cells.
module addsub_slice
    import serial_addsub_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic [BITS_PER_CYCLE-1:0] x,
    input  logic [BITS_PER_CYCLE-1:0] y,
    input  logic                      mode,
    input  logic                      cin,
    output logic [BITS_PER_CYCLE-1:0] r,
    output logic                      cout
);

    genvar i;
    for (i = 0; i < BITS_PER_CYCLE; i++) begin : g_cell
        logic ci;
        logic co;
        logic xe;
        if (i == 0) begin : g_first
            assign ci = cin;
        end else begin : g_next
            assign ci = g_cell[i-1].co;
        end
        // Borrow is the majority of (~x, y, bin); carry is the majority of (x, y, cin).
        assign xe   = (mode == MODE_ADD) ? x[i] : ~x[i];
        assign r[i] = x[i] ^ y[i] ^ ci;
        assign co   = (xe & y[i]) | (xe & ci) | (y[i] & ci);
    end

    assign cout = g_cell[BITS_PER_CYCLE-1].co;

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor: processes BITS_PER_CYCLE bits per clock, LSB slice first,
// with a start/ready/done handshake and registered result and flags.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             in_ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero
);

    localparam int NSLICE = WIDTH / BITS_PER_CYCLE;
    localparam int CW     = $clog2(NSLICE) + 1;

    if ((WIDTH % BITS_PER_CYCLE) != 0) begin : g_bad_split
        $error("serial_addsub: WIDTH (%0d) not divisible by BITS_PER_CYCLE (%0d)", WIDTH, BITS_PER_CYCLE);
    end
    if (WIDTH < 2) begin : g_bad_width
        $error("serial_addsub: WIDTH (%0d) must be >= 2", WIDTH);
    end

    state_t                    state;
    logic [WIDTH-1:0]          sa;
    logic [WIDTH-1:0]          sb;
    logic [WIDTH-1:0]          res_sh;
    logic [WIDTH-1:0]          nxt_res;
    logic                      mode_q;
    logic                      chain;
    logic                      a_msb;
    logic                      b_msb;
    logic [CW-1:0]             cnt;
    logic [BITS_PER_CYCLE-1:0] sl_r;
    logic                      sl_cout;
    logic                      nxt_ovf;

    addsub_slice #(
        .BITS_PER_CYCLE(BITS_PER_CYCLE)
    ) u_slice (
        .x    (sa[BITS_PER_CYCLE-1:0]),
        .y    (sb[BITS_PER_CYCLE-1:0]),
        .mode (mode_q),
        .cin  (chain),
        .r    (sl_r),
        .cout (sl_cout)
    );

    // Operand MSBs shift out before the last slice, so they are captured at start for the flags.
    always_comb begin
        nxt_res = res_sh >> BITS_PER_CYCLE;
        nxt_res[WIDTH-1 -: BITS_PER_CYCLE] = sl_r;
        if (mode_q == MODE_ADD)
            nxt_ovf = (a_msb == b_msb) & (nxt_res[WIDTH-1] != a_msb);
        else
            nxt_ovf = (a_msb != b_msb) & (nxt_res[WIDTH-1] != a_msb);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            sa        <= '0;
            sb        <= '0;
            res_sh    <= '0;
            mode_q    <= 1'b0;
            chain     <= 1'b0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        sa       <= a;
                        sb       <= b;
                        mode_q   <= mode;
                        a_msb    <= a[WIDTH-1];
                        b_msb    <= b[WIDTH-1];
                        chain    <= 1'b0;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    sa     <= sa >> BITS_PER_CYCLE;
                    sb     <= sb >> BITS_PER_CYCLE;
                    res_sh <= nxt_res;
                    chain  <= sl_cout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(NSLICE - 1)) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        result    <= nxt_res;
                        carry_out <= sl_cout;
                        overflow  <= nxt_ovf;
                        zero      <= ~|nxt_res;
                    end
                end
                DONE: begin
                    done     <= 1'b0;
                    in_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub (8-bit at 1 and 4 bits per cycle).
module tb_serial_addsub;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       start = 1'b0, mode = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic       in_ready, done, carry_out, overflow, zero;
    logic [7:0] result;

    logic       start4 = 1'b0, mode4 = 1'b0;
    logic [7:0] a4 = '0, b4 = '0;
    logic       in_ready4, done4, carry_out4, overflow4, zero4;
    logic [7:0] result4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
        .in_ready(in_ready), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero)
    );

    serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4),
        .in_ready(in_ready4), .done(done4), .result(result4),
        .carry_out(carry_out4), .overflow(overflow4), .zero(zero4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run8(input string tag, input logic m, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [7:0] er, input logic ec, input logic eo, input logic ez);
        int lat;
        wait_ready();
        a = ia; b = ib; mode = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, lat, 9);
        check({tag, ".result"}, {24'd0, result}, {24'd0, er});
        check({tag, ".carry"}, {31'd0, carry_out}, {31'd0, ec});
        check({tag, ".overflow"}, {31'd0, overflow}, {31'd0, eo});
        check({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    endtask

    initial begin
        int ndone;
        int lat;
        logic [7:0] cap;

        #12;
        check("rst.in_ready", {31'd0, in_ready}, 1);
        check("rst.done", {31'd0, done}, 0);
        check("rst.result", {24'd0, result}, 0);
        check("rst.carry", {31'd0, carry_out}, 0);
        check("rst.zero", {31'd0, zero}, 0);
        check("rst.in_ready4", {31'd0, in_ready4}, 1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        run8("sub05_03", 1'b0, 8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b0);
        run8("sub03_05", 1'b0, 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0);
        run8("sub80_01", 1'b0, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
        run8("addFF_01", 1'b1, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1);
        run8("add7F_01", 1'b1, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);

        // start pulses during RUN must be ignored
        wait_ready();
        a = 8'h12; b = 8'h34; mode = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        cap = '0;
        for (int i = 1; i <= 14; i++) begin
            if (i == 2 || i == 4) begin
                a = 8'hAA; b = 8'h55; mode = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                cap = result;
            end
        end
        start = 1'b0;
        check("busy.done_count", ndone, 1);
        check("busy.result", {24'd0, cap}, 32'h46);
        check("busy.in_ready", {31'd0, in_ready}, 1);

        // reset in the middle of RUN
        a = 8'h05; b = 8'h03; mode = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("midrst.busy", {31'd0, in_ready}, 0);
        rst = 1'b1;
        #1;
        check("midrst.in_ready", {31'd0, in_ready}, 1);
        check("midrst.done", {31'd0, done}, 0);
        check("midrst.result", {24'd0, result}, 0);
        check("midrst.carry", {31'd0, carry_out}, 0);
        check("midrst.overflow", {31'd0, overflow}, 0);
        check("midrst.zero", {31'd0, zero}, 0);
        @(negedge clk) rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        check("midrst.no_done", ndone, 0);

        // four bits per cycle
        a4 = 8'h10; b4 = 8'h01; mode4 = 1'b0; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat = 1;
        while (!done4 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("bpc4.latency", lat, 3);
        check("bpc4.result", {24'd0, result4}, 32'h0F);
        check("bpc4.carry", {31'd0, carry_out4}, 0);
        check("bpc4.overflow", {31'd0, overflow4}, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
